// File: rtl/trivia_buzz_pkg.sv
// Shared types and constants for the trivia buzzer arbiter.
// Includes the round-robin pick used to break simultaneous buzzes.
package trivia_buzz_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_WINDOW = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Lowest offset from ptr wins; scanning downward lets it overwrite.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] req,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/buzz_sync_edge.sv
// Two-flop synchronizer for one buzzer pin plus a rising-edge pulse.
// The pulse is one clock wide and follows the second sync flop.
module buzz_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic buzz,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= buzz;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign pulse = sync2 & ~sync_d;

endmodule

// File: rtl/trivia_buzzer_arbiter.sv
// Avalon-MM trivia buzzer arbiter: first qualified buzz locks the round,
// an answer-window counter times out otherwise.
module trivia_buzzer_arbiter
    import trivia_buzz_pkg::*;
#(
    parameter int TIMER_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  buzz_in,
    output logic [1:0]  winner_id,
    output logic        winner_valid,
    output logic        armed,
    output logic        irq
);

    state_t               state_q;
    state_t               state_d;
    logic [TIMER_W-1:0]   count_q;
    logic [TIMER_W-1:0]   window_q;
    logic [3:0]           mask_q;
    logic                 irq_en_q;
    logic [1:0]           ptr_q;
    logic [1:0]           winner_q;
    logic                 timed_out_q;
    logic [3:0]           edges;
    logic [3:0]           qual;
    logic [1:0]           pick;
    logic                 wr;
    logic                 wr_ctrl;
    logic                 arm_req;
    logic                 abort_req;
    logic                 lock;
    logic                 expire;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_sync
        buzz_sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .buzz    (buzz_in[p]),
            .pulse   (edges[p])
        );
    end

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign abort_req = wr_ctrl & writedata[CTRL_ABORT];
    assign arm_req   = wr_ctrl & writedata[CTRL_ARM] & ~abort_req;
    assign qual      = edges & ~mask_q;
    assign pick      = rr_pick(qual, ptr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Software commands override whatever the round was doing.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_ARMED) begin
            if (|qual)              state_d = ST_LOCKED;
            else if (count_q == '0) state_d = ST_TIMEOUT;
        end
        if (arm_req)   state_d = ST_ARMED;
        if (abort_req) state_d = ST_IDLE;
    end

    always_comb begin
        winner_valid = (state_q == ST_LOCKED);
        armed        = (state_q == ST_ARMED);
        irq          = irq_en_q &
                       ((state_q == ST_LOCKED) | (state_q == ST_TIMEOUT));
    end

    assign lock   = (state_q == ST_ARMED) && (state_d == ST_LOCKED);
    assign expire = (state_q == ST_ARMED) && (state_d == ST_TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            window_q    <= '0;
            mask_q      <= '0;
            irq_en_q    <= 1'b0;
            ptr_q       <= 2'd0;
            winner_q    <= 2'd0;
            timed_out_q <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en_q <= writedata[CTRL_IRQ_EN];
            if (wr && address == ADDR_WINDOW)
                window_q <= writedata[TIMER_W-1:0];
            if (wr && address == ADDR_MASK)
                mask_q <= writedata[3:0];
            if (arm_req) begin
                count_q     <= window_q;
                timed_out_q <= 1'b0;
            end else if (state_q == ST_ARMED && state_d == ST_ARMED) begin
                count_q <= count_q - 1'b1;
            end
            if (expire)
                timed_out_q <= 1'b1;
            if (lock) begin
                winner_q <= pick;
                ptr_q    <= pick + 2'd1;
            end
        end
    end

    assign winner_id = winner_q;

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_CTRL:   readdata = {29'd0, irq_en_q, state_q};
            ADDR_STATUS: readdata = {28'd0, timed_out_q, winner_q, winner_valid};
            ADDR_WINDOW: readdata = 32'(window_q);
            ADDR_MASK:   readdata = {28'd0, mask_q};
        endcase
    end

endmodule

// File: tb/tb_trivia_buzzer_arbiter.sv
// Directed self-checking bench for trivia_buzzer_arbiter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_trivia_buzzer_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  buzz_in;
    logic [1:0]  winner_id;
    logic        winner_valid;
    logic        armed;
    logic        irq;

    int checks;
    int errors;

    trivia_buzzer_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .buzz_in      (buzz_in),
        .winner_id    (winner_id),
        .winner_valid (winner_valid),
        .armed        (armed),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic apply_reset;
        reset_n    = 1'b0;
        buzz_in    = 4'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        apply_reset();
        checks++;
        if ({winner_valid, winner_id, armed, irq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {winner_valid, winner_id, armed, irq});
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %h want 0", d);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got %h want 0", d);
        end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_window got %h want 0", d);
        end
    endtask

    task automatic test_single_buzz;
        logic [31:0] d;
        apply_reset();
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h5);
        buzz_in[2] = 1'b1;
        tick(1);
        checks++;
        if (winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL buzz_edge1 got %b want 0", winner_valid);
        end
        tick(1);
        checks++;
        if (winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL buzz_edge2 got %b want 0", winner_valid);
        end
        tick(1);
        checks++;
        if ({winner_valid, winner_id, irq} !== 4'b1101) begin
            errors++;
            $display("FAIL buzz_edge3 got %b want 1101",
                     {winner_valid, winner_id, irq});
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL buzz_status got %h want 5", d);
        end
        bus_write(2'd1, 32'hF);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL status_ro got %h want 5", d);
        end
        buzz_in = 4'd0;
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        apply_reset();
        bus_write(2'd2, 32'd5);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (armed !== 1'b1) begin
                errors++;
                $display("FAIL timeout_armed%0d got %b want 1", i, armed);
            end
            if (i < 5) tick(1);
        end
        tick(1);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL timeout_state got %h want 3", d);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL timeout_status got %h want 8", d);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] want [3];
        want[0] = 2'd1;
        want[1] = 2'd3;
        want[2] = 2'd1;
        apply_reset();
        bus_write(2'd2, 32'd100);
        for (int r = 0; r < 3; r++) begin
            bus_write(2'd0, 32'h1);
            buzz_in = 4'b1010;
            tick(3);
            checks++;
            if ({winner_valid, winner_id, irq} !== {1'b1, want[r], 1'b0}) begin
                errors++;
                $display("FAIL rr_round%0d got %b want %b", r,
                         {winner_valid, winner_id, irq},
                         {1'b1, want[r], 1'b0});
            end
            buzz_in = 4'd0;
            tick(3);
        end
    endtask

    task automatic test_mask;
        logic [31:0] d;
        apply_reset();
        bus_write(2'd3, 32'h1);
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h1);
        buzz_in[0] = 1'b1;
        tick(10);
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL mask_p0 got armed=%b want 1", armed);
        end
        buzz_in[1] = 1'b1;
        tick(3);
        checks++;
        if ({winner_valid, winner_id} !== 3'b101) begin
            errors++;
            $display("FAIL mask_p1 got %b want 101",
                     {winner_valid, winner_id});
        end
        buzz_in = 4'd0;
        tick(3);
        bus_write(2'd3, 32'h0);
        buzz_in[0] = 1'b1;
        tick(4);
        bus_write(2'd2, 32'd20);
        bus_write(2'd0, 32'h1);
        tick(25);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h3 || winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_button got ctrl=%h wv=%b want 3/0",
                     d, winner_valid);
        end
        buzz_in = 4'd0;
    endtask

    task automatic test_last_cycle_buzz;
        logic [31:0] d;
        apply_reset();
        bus_write(2'd2, 32'd10);
        bus_write(2'd0, 32'h5);
        tick(8);
        buzz_in[3] = 1'b1;
        tick(2);
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL lastcyc_armed got %b want 1", armed);
        end
        tick(1);
        checks++;
        if ({winner_valid, winner_id, irq} !== 4'b1111) begin
            errors++;
            $display("FAIL lastcyc_lock got %b want 1111",
                     {winner_valid, winner_id, irq});
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h7) begin
            errors++;
            $display("FAIL lastcyc_status got %h want 7", d);
        end
        bus_write(2'd0, 32'h7);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort got ctrl=%h irq=%b want 4/0", d, irq);
        end
        buzz_in = 4'd0;
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        apply_reset();
        bus_write(2'd2, 32'd50);
        bus_write(2'd0, 32'h5);
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({winner_valid, winner_id, armed, irq} !== 5'b0) begin
            errors++;
            $display("FAIL async_rst_out got %b want 00000",
                     {winner_valid, winner_id, armed, irq});
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL async_rst_ctrl got %h want 0", d);
        end
        tick(1);
        reset_n = 1'b1;
        tick(1);
        buzz_in[2] = 1'b1;
        tick(2);
        buzz_in = 4'd0;
        tick(4);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0 || winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_buzz got ctrl=%h wv=%b want 0/0",
                     d, winner_valid);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        buzz_in    = 4'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        test_reset();
        test_single_buzz();
        test_timeout();
        test_round_robin();
        test_mask();
        test_last_cycle_buzz();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
